// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard: tracks in-flight destinations past D, drives the D-stage
// stall, per-source forwarding selects, a HI/LO busy interlock and a saturating stall counter.
module hazard_scoreboard #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned AW     = 5,
  parameter int unsigned TW     = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           d_valid,
  input  logic [AW-1:0]                  d_rs,
  input  logic [AW-1:0]                  d_rt,
  input  logic                           d_use_rs,
  input  logic                           d_use_rt,
  input  logic [TW-1:0]                  d_tuse_rs,
  input  logic [TW-1:0]                  d_tuse_rt,
  input  logic                           d_regwrite,
  input  logic [AW-1:0]                  d_wa,
  input  logic [TW-1:0]                  d_tnew,
  input  logic                           d_md,
  input  logic                           md_busy,
  input  logic                           flush,
  output logic                           stall,
  output logic [$clog2(STAGES+1)-1:0]    fwd_rs_sel,
  output logic [$clog2(STAGES+1)-1:0]    fwd_rt_sel,
  output logic                           fwd_rs_rdy,
  output logic                           fwd_rt_rdy,
  output logic [CNT_W-1:0]               stall_cnt
);

  localparam int unsigned SW = $clog2(STAGES + 1);

  logic              r_v    [1:STAGES];
  logic [AW-1:0]     r_wa   [1:STAGES];
  logic [TW-1:0]     r_tnew [1:STAGES];
  logic [CNT_W-1:0]  r_cnt;

  logic [SW-1:0]     w_rs_sel;
  logic [SW-1:0]     w_rt_sel;
  logic              w_rs_rdy;
  logic              w_rt_rdy;
  logic              w_rs_late;
  logic              w_rt_late;
  logic              w_stall;

  // Youngest match wins: scan oldest to youngest so the smallest index is written last.
  always_comb begin
    w_rs_sel  = '0;
    w_rt_sel  = '0;
    w_rs_rdy  = 1'b0;
    w_rt_rdy  = 1'b0;
    w_rs_late = 1'b0;
    w_rt_late = 1'b0;
    for (int i = int'(STAGES); i >= 1; i--) begin
      if (r_v[i] && (r_wa[i] == d_rs) && (d_rs != '0)) begin
        w_rs_sel  = SW'(i);
        w_rs_rdy  = (r_tnew[i] == '0);
        w_rs_late = (r_tnew[i] > d_tuse_rs);
      end
      if (r_v[i] && (r_wa[i] == d_rt) && (d_rt != '0)) begin
        w_rt_sel  = SW'(i);
        w_rt_rdy  = (r_tnew[i] == '0);
        w_rt_late = (r_tnew[i] > d_tuse_rt);
      end
    end
    w_stall = (d_valid & d_use_rs & w_rs_late)
            | (d_valid & d_use_rt & w_rt_late)
            | (d_valid & d_md & md_busy);
  end

  // Shift scoreboard; tnew saturates at zero as entries age.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= int'(STAGES); i++) begin
        r_v[i]    <= 1'b0;
        r_wa[i]   <= '0;
        r_tnew[i] <= '0;
      end
      r_cnt <= '0;
    end else begin
      if (w_stall) begin
        r_v[1]    <= 1'b0;
        r_wa[1]   <= '0;
        r_tnew[1] <= '0;
      end else begin
        r_v[1]    <= d_valid & d_regwrite & (d_wa != '0);
        r_wa[1]   <= d_wa;
        r_tnew[1] <= d_tnew;
      end
      for (int i = 2; i <= int'(STAGES); i++) begin
        r_v[i]    <= r_v[i-1];
        r_wa[i]   <= r_wa[i-1];
        r_tnew[i] <= (r_tnew[i-1] == '0) ? '0 : r_tnew[i-1] - TW'(1);
      end
      if (flush) begin
        for (int i = 1; i <= int'(STAGES); i++) begin
          r_v[i] <= 1'b0;
        end
      end
      if (w_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign stall      = w_stall;
  assign fwd_rs_sel = w_rs_sel;
  assign fwd_rt_sel = w_rt_sel;
  assign fwd_rs_rdy = w_rs_rdy;
  assign fwd_rt_rdy = w_rt_rdy;
  assign stall_cnt  = r_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus random traffic
// against a model that tracks instructions by age since entering E.
module tb_hazard_scoreboard;

  localparam int unsigned STAGES = 3;
  localparam int unsigned AW     = 5;
  localparam int unsigned TW     = 2;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned SW     = $clog2(STAGES + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              d_valid;
  logic [AW-1:0]     d_rs, d_rt, d_wa;
  logic              d_use_rs, d_use_rt, d_regwrite, d_md, md_busy, flush;
  logic [TW-1:0]     d_tuse_rs, d_tuse_rt, d_tnew;
  logic              stall, fwd_rs_rdy, fwd_rt_rdy;
  logic [SW-1:0]     fwd_rs_sel, fwd_rt_sel;
  logic [CNT_W-1:0]  stall_cnt;

  hazard_scoreboard #(.STAGES(STAGES), .AW(AW), .TW(TW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_regwrite(d_regwrite), .d_wa(d_wa), .d_tnew(d_tnew), .d_md(d_md), .md_busy(md_busy),
    .flush(flush), .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .fwd_rs_rdy(fwd_rs_rdy), .fwd_rt_rdy(fwd_rt_rdy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; int rs; bit urs; int tus; int rt; bit urt; int tut;
    bit rw; int wa; int tn; bit md; bit mb; bit fl;
  } din_t;

  // One record per instruction that entered E; hist[k] entered k+1 edges ago's worth of stages.
  typedef struct { bit v; int wa; int t0; } ent_t;

  ent_t   hist[$];
  longint m_cnt;
  int     n_checks;
  int     n_errors;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ent_t e;
    e.v = 1'b0; e.wa = 0; e.t0 = 0;
    hist.delete();
    for (int k = 0; k < int'(STAGES); k++) hist.push_back(e);
    m_cnt = 0;
  endtask

  // Stage i holds the instruction that entered E i-1 edges ago; its latency has shrunk by i-1.
  function automatic void lookup(input int src, output int sel, output int tn);
    sel = 0; tn = 0;
    for (int i = 1; i <= int'(STAGES); i++) begin
      if (sel == 0 && hist[i-1].v && hist[i-1].wa == src && src != 0) begin
        sel = i;
        tn  = (hist[i-1].t0 > i - 1) ? hist[i-1].t0 - (i - 1) : 0;
      end
    end
  endfunction

  function automatic din_t mk(bit v, int rs, bit urs, int tus, int rt, bit urt, int tut,
                              bit rw, int wa, int tn);
    din_t d;
    d.v = v; d.rs = rs; d.urs = urs; d.tus = tus; d.rt = rt; d.urt = urt; d.tut = tut;
    d.rw = rw; d.wa = wa; d.tn = tn; d.md = 1'b0; d.mb = 1'b0; d.fl = 1'b0;
    return d;
  endfunction

  // Drive one D-stage cycle, check all outputs against the model, then advance the model.
  task automatic step(input din_t d, output bit e_stall);
    int  s_rs, t_rs, s_rt, t_rt;
    ent_t ne;
    @(negedge clk);
    d_valid = d.v; d_rs = AW'(d.rs); d_use_rs = d.urs; d_tuse_rs = TW'(d.tus);
    d_rt = AW'(d.rt); d_use_rt = d.urt; d_tuse_rt = TW'(d.tut);
    d_regwrite = d.rw; d_wa = AW'(d.wa); d_tnew = TW'(d.tn);
    d_md = d.md; md_busy = d.mb; flush = d.fl;
    #1;
    lookup(d.rs, s_rs, t_rs);
    lookup(d.rt, s_rt, t_rt);
    e_stall = (d.v && d.urs && s_rs != 0 && t_rs > d.tus) ||
              (d.v && d.urt && s_rt != 0 && t_rt > d.tut) ||
              (d.v && d.md && d.mb);
    check("stall",      stall,      e_stall);
    check("fwd_rs_sel", fwd_rs_sel, s_rs);
    check("fwd_rt_sel", fwd_rt_sel, s_rt);
    check("fwd_rs_rdy", fwd_rs_rdy, (s_rs != 0 && t_rs == 0));
    check("fwd_rt_rdy", fwd_rt_rdy, (s_rt != 0 && t_rt == 0));
    check("stall_cnt",  stall_cnt,  m_cnt);
    ne.v  = d.v && d.rw && d.wa != 0 && !e_stall;
    ne.wa = d.wa;
    ne.t0 = d.tn;
    hist.push_front(ne);
    void'(hist.pop_back());
    if (d.fl) foreach (hist[k]) hist[k].v = 1'b0;
    if (e_stall && m_cnt != (64'd1 << CNT_W) - 1) m_cnt++;
  endtask

  initial begin
    din_t   d, last;
    bit     st, prev_st;
    longint base;
    n_checks = 0; n_errors = 0;
    reset = 1'b1;
    d_valid = 0; d_rs = '0; d_rt = '0; d_use_rs = 0; d_use_rt = 0; d_tuse_rs = '0;
    d_tuse_rt = '0; d_regwrite = 0; d_wa = '0; d_tnew = '0; d_md = 0; md_busy = 0; flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    check("rst_stall", stall, 0);
    check("rst_sel",   fwd_rs_sel, 0);
    check("rst_rdy",   fwd_rs_rdy, 0);
    check("rst_cnt",   stall_cnt, 0);

    // lw $1 (tnew 3) then add $2,$1,$1 (tuse 1): two stall cycles
    base = m_cnt;
    step(mk(1, 0,0,0, 0,0,0, 1,1,3), st);
    for (int k = 0; k < 3; k++) step(mk(1, 1,1,1, 1,1,1, 1,2,1), st);
    check("lw_use_stalls", longint'(stall_cnt) - base, 2);
    check("lw_use_sel", fwd_rs_sel, 3);

    // ori $3 (tnew 2) then beq $3,$0 (tuse 0): two stalls, then ready forward
    base = m_cnt;
    step(mk(1, 0,0,0, 0,0,0, 1,3,2), st);
    for (int k = 0; k < 3; k++) step(mk(1, 3,1,0, 0,1,0, 0,0,0), st);
    check("ori_beq_stalls", longint'(stall_cnt) - base, 2);
    check("ori_beq_rdy", fwd_rs_rdy, 1);

    // add $4, ori $4, sw rt=$4: youngest producer selected, no stall
    step(mk(1, 0,0,0, 0,0,0, 1,4,1), st);
    step(mk(1, 0,0,0, 0,0,0, 1,4,1), st);
    step(mk(1, 0,0,0, 4,1,2, 0,0,0), st);
    check("sw_youngest", fwd_rt_sel, 1);

    // writes to $0 never hazard
    step(mk(1, 0,0,0, 0,0,0, 1,0,3), st);
    step(mk(1, 0,1,0, 0,1,0, 1,6,1), st);
    check("zero_reg_sel", fwd_rs_sel, 0);

    // HI/LO interlock for five busy cycles
    base = m_cnt;
    d = mk(1, 0,0,0, 0,0,0, 0,0,0); d.md = 1'b1; d.mb = 1'b1;
    for (int k = 0; k < 5; k++) step(d, st);
    d.mb = 1'b0;
    step(d, st);
    check("md_stalls", longint'(stall_cnt) - base, 5);

    // flush during pending lw $5 hazard
    step(mk(1, 0,0,0, 0,0,0, 1,5,3), st);
    d = mk(1, 5,1,0, 0,0,0, 0,0,0); d.fl = 1'b1;
    step(d, st);
    d.fl = 1'b0;
    step(d, st);
    check("flush_stall", stall, 0);

    // async reset asserted while stalled
    step(mk(1, 0,0,0, 0,0,0, 1,7,3), st);
    step(mk(1, 7,1,0, 0,0,0, 0,0,0), st);
    #2 reset = 1'b1;
    #1;
    check("arst_stall", stall, 0);
    check("arst_cnt",   stall_cnt, 0);
    @(negedge clk); reset = 1'b0;
    model_reset();

    // random traffic; D held constant while the model says stalled
    prev_st = 1'b0;
    last = mk(0, 0,0,0, 0,0,0, 0,0,0);
    for (int n = 0; n < 3000; n++) begin
      if (prev_st) d = last;
      else begin
        d = mk($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 3));
        d.md = ($urandom_range(0, 7) == 0);
      end
      d.mb = ($urandom_range(0, 3) == 0);
      d.fl = ($urandom_range(0, 19) == 0);
      step(d, st);
      last = d;
      prev_st = st;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
